// File: rtl/countdown_timer_ctrl.sv
// Countdown timer controller: a 1-tick prescaler drives a down-counter through
// IDLE/RUN/PAUSE/DONE, with registered tick, done and alarm outputs.
module countdown_timer_ctrl #(
  parameter int TICK_DIV = 50_000_000,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pause,
  input  logic             clear,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] remain,
  output logic             tick_o,
  output logic             done_o,
  output logic             alarm_o,
  output logic [1:0]       state_o
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   remain_q, remain_d;
  logic [PRE_W-1:0]   pre_cnt_q, pre_cnt_d;
  logic               tick_q, tick_d;
  logic               done_q, done_d;
  logic               alarm_q, alarm_d;
  logic               terminal;

  // Next-state, prescaler and counter update; clear dominates, then pause, then start.
  always_comb begin
    terminal  = (state_q == ST_RUN) && (pre_cnt_q == PRE_MAX);
    state_d   = state_q;
    remain_d  = remain_q;
    pre_cnt_d = pre_cnt_q;
    tick_d    = 1'b0;
    alarm_d   = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        pre_cnt_d = '0;
        if (clear) begin
          state_d  = ST_IDLE;
          remain_d = '0;
        end else if (start) begin
          remain_d = load_val;
          if (load_val == '0) begin
            state_d = ST_DONE;
            alarm_d = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = state_q;
        end
      end

      ST_RUN: begin
        if (clear) begin
          state_d   = ST_IDLE;
          remain_d  = '0;
          pre_cnt_d = '0;
        end else if (terminal) begin
          // A tick coinciding with pause still lands; reaching zero wins over pause.
          pre_cnt_d = '0;
          remain_d  = remain_q - CNT_W'(1);
          tick_d    = 1'b1;
          if (remain_q == CNT_W'(1)) begin
            state_d = ST_DONE;
            alarm_d = 1'b1;
          end else if (pause) begin
            state_d = ST_PAUSE;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          pre_cnt_d = pre_cnt_q + PRE_W'(1);
          if (pause) begin
            state_d = ST_PAUSE;
          end else begin
            state_d = ST_RUN;
          end
        end
      end

      ST_PAUSE: begin
        if (clear) begin
          state_d   = ST_IDLE;
          remain_d  = '0;
          pre_cnt_d = '0;
        end else if (start) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_PAUSE;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        remain_d  = '0;
        pre_cnt_d = '0;
      end
    endcase

    done_d = (state_d == ST_DONE);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      remain_q  <= '0;
      pre_cnt_q <= '0;
      tick_q    <= 1'b0;
      done_q    <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      remain_q  <= remain_d;
      pre_cnt_q <= pre_cnt_d;
      tick_q    <= tick_d;
      done_q    <= done_d;
      alarm_q   <= alarm_d;
    end
  end

  assign remain  = remain_q;
  assign tick_o  = tick_q;
  assign done_o  = done_q;
  assign alarm_o = alarm_q;
  assign state_o = state_q;

endmodule

// File: doc/countdown_timer_ctrl.md
Name: countdown_timer_ctrl

Overview:
- Controller that sequences a 1 s prescaler and a countdown register: load, start, pause/resume, clear, and expiry signalling.
- Sits between the board push-button / switch logic (already debounced, single-cycle pulses) and the display/LED logic.
- Owns its own prescaler, so no separate divided clock is generated; all logic runs on clk and uses enable pulses.

Parameters:
- TICK_DIV, 50_000_000, clk cycles per tick; 1 s at a 20 ns clk. Legal range is ≥2; use 4 in simulation.
- CNT_W, 8, width of the countdown value.

Ports:
- clk  input  1  system clock, 20 ns
- rst  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse; start from IDLE/DONE, resume from PAUSE
- pause  input  1  one-cycle pulse; pause while RUN
- clear  input  1  one-cycle pulse; abort to IDLE from any state
- load_val  input  CNT_W  initial count, sampled only on an accepted start from IDLE/DONE
- remain  output  CNT_W  current remaining count
- tick_o  output  1  one-cycle pulse on each counted tick
- done_o  output  1  level, high while in DONE
- alarm_o  output  1  one-cycle pulse on entry to DONE
- state_o  output  2  IDLE=0, RUN=1, PAUSE=2, DONE=3

Behaviour:
- Reset (rst high, asynchronous, any time): state IDLE, remain=0, prescaler=0, tick_o=0, done_o=0, alarm_o=0. Mid-run reset aborts with no alarm.
- All outputs are registered.
- Prescaler pre_cnt has width ceil(log2(TICK_DIV)).
  - Counts 0..TICK_DIV-1 only in RUN.
  - Held in PAUSE.
  - Forced to 0 in IDLE, DONE, on clear, and on any start out of IDLE/DONE.
- Terminal event: state RUN and pre_cnt==TICK_DIV-1 at a clk edge.
  - pre_cnt wraps to 0.
  - remain decrements by 1.
  - tick_o is 1 for the following cycle.
  - First tick is TICK_DIV edges after the start edge.
- Command priority when pulses coincide: clear > pause > start.
- IDLE:
  - start: remain<=load_val. If load_val==0, go to DONE (alarm_o pulses). Otherwise go to RUN.
  - pause: ignored.
- RUN:
  - clear: go to IDLE, remain<=0, no tick emitted even if terminal that cycle.
  - pause: go to PAUSE. If terminal in the same cycle, the tick still takes effect (decrement plus tick_o).
  - Terminal with remain==1: remain<=0, go to DONE, tick_o=1 and alarm_o=1 in the same cycle.
  - start: ignored.
- PAUSE:
  - start: go to RUN; pre_cnt resumes from its held value, so no time is lost or gained.
  - clear: go to IDLE.
  - pause: ignored.
- DONE:
  - done_o=1; remain holds 0.
  - start: reload load_val and behave as a start from IDLE.
  - clear: go to IDLE.
- remain never underflows: no decrement occurs outside RUN, and RUN always exits at 0.
- alarm_o fires exactly once per expiry.
- state_o reflects the registered state and changes on the edge after the command.

Test Plan (TICK_DIV=4, CNT_W=8):
1. Basic countdown: rst, then start with load_val=3 at edge E0.
   - tick_o after E4, E8, E12.
   - remain goes 3→2→1→0.
   - At E12: state_o=3, alarm_o=1 for exactly one cycle, done_o stays 1.
2. Pause/resume: load 5, start at E0, pause at E6, hold 20 cycles, start again.
   - During PAUSE: remain=4, no tick_o.
   - After resume: the next tick arrives 2 edges after resume (pre_cnt was held at 2).
   - Total tick count is 5.
3. Simultaneous events, load 5:
   - pause on a terminal edge: remain decrements and state becomes PAUSE.
   - clear on a terminal edge: state IDLE, remain=0, tick_o stays 0.
   - start+pause+clear together in RUN: IDLE.
4. Zero and restart:
   - start with load_val=0: DONE on the next edge, alarm_o pulses once, no tick_o.
   - start again from DONE with load_val=2: RUN, expires after 8 edges.
5. Async reset mid-RUN (remain=7):
   - Assert rst between edges: all outputs 0 immediately, before the next clk edge.
   - After release: the next start counts normally.
6. Ignored commands: pause in IDLE, start in RUN, and pause in DONE do not change state_o, remain, or pre_cnt timing.
